// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips_ctrl_pkg : state, opcode and select encodings for multicycle_control
// Optional feature macro: CTRL_JAL_EN
// Revision: 1.0
// ============================================================================
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BEQ      = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11,
      S_TRAP     = 4'd12,
      S_JAL      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic       ext_zero;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic state_t decode_target(input logic [5:0] op);
      state_t s;
      case (op)
         OP_RTYPE:        s = S_R_EXEC;
         OP_LW, OP_SW:    s = S_MEM_ADDR;
         OP_BEQ:          s = S_BEQ;
         OP_ADDI, OP_ORI: s = S_I_EXEC;
         OP_J:            s = S_JUMP;
`ifdef CTRL_JAL_EN
         OP_JAL:          s = S_JAL;
`endif
         default:         s = S_TRAP;
      endcase
      return s;
   endfunction

   // Moore part of the outputs; the FETCH handshake terms are added in the top.
   function automatic ctrl_t state_outputs(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_source = PCSRC_ALU;
         end
         S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            if (op == OP_ORI) begin
               c.alu_op   = ALU_OR;
               c.ext_zero = 1'b1;
            end
         end
         S_I_WB: c.reg_write = 1'b1;
`ifdef CTRL_JAL_EN
         // reg_dst=1 with mem_to_reg=1 selects $ra as target and PC as data.
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCSRC_JUMP;
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.mem_to_reg = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// mem_wait_timer : counts memory stall cycles, flags timeout on the last one
// Revision: 1.0
// ============================================================================
module mem_wait_timer #(
   parameter int WAIT_MAX = 15,
   parameter int WAIT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic clear,
   output logic timeout
);

   localparam logic [WAIT_W-1:0] LAST_STALL = WAIT_W'(WAIT_MAX - 1);

   logic [WAIT_W-1:0] count;

   // Fires on the stall cycle that would bring the count to WAIT_MAX.
   assign timeout = stall && (count == LAST_STALL);

   always_ff @(posedge clk) begin
      if (reset || clear || timeout) begin
         count <= '0;
      end else if (stall) begin
         count <= count + WAIT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : multi-cycle MIPS-32 main control FSM
// Optional feature macro: CTRL_JAL_EN (adds the jal sequence)
// Revision: 1.0
// ============================================================================
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int WAIT_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       reg_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic       ext_zero,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_fault,
   output logic [3:0] state
);

   state_t     cur_state;
   state_t     next_state;
   logic [5:0] op_reg;
   logic [5:0] next_op;
   ctrl_t      outs;
   logic       stall;
   logic       timeout;
   logic       fetch_done;

   assign stall = ((cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                   (cur_state == S_MEM_WR)) && !mem_ready;
   assign fetch_done = (cur_state == S_FETCH) && mem_ready;
   assign next_op    = (cur_state == S_DECODE) ? opcode : op_reg;

   mem_wait_timer #(
      .WAIT_MAX(WAIT_MAX),
      .WAIT_W  (WAIT_W)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .stall  (stall),
      .clear  (!stall),
      .timeout(timeout)
   );

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         S_FETCH:    if (mem_ready) next_state = S_DECODE;
         S_DECODE:   next_state = decode_target(opcode);
         S_MEM_ADDR: next_state = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready)    next_state = S_MEM_WB;
            else if (timeout) next_state = S_FETCH;
         end
         S_MEM_WR:   if (mem_ready || timeout) next_state = S_FETCH;
         S_R_EXEC:   next_state = S_R_WB;
         S_I_EXEC:   next_state = S_I_WB;
         S_TRAP:     next_state = S_TRAP;
         default:    next_state = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state  <= S_FETCH;
         op_reg     <= '0;
         outs       <= state_outputs(S_FETCH, 6'b000000);
         illegal_op <= 1'b0;
         mem_fault  <= 1'b0;
      end else begin
         cur_state <= next_state;
         if (cur_state == S_DECODE) op_reg <= opcode;
         outs      <= state_outputs(next_state, next_op);
         if (next_state == S_TRAP) illegal_op <= 1'b1;
         mem_fault <= timeout;
      end
   end

   assign ir_write      = fetch_done;
   assign pc_write      = outs.pc_write | fetch_done;
   assign pc_write_cond = outs.pc_write_cond;
   assign reg_write     = outs.reg_write;
   assign i_or_d        = outs.i_or_d;
   assign mem_read      = outs.mem_read;
   assign mem_write     = outs.mem_write;
   assign mem_to_reg    = outs.mem_to_reg;
   assign reg_dst       = outs.reg_dst;
   assign alu_src_a     = outs.alu_src_a;
   assign ext_zero      = outs.ext_zero;
   assign alu_src_b     = outs.alu_src_b;
   assign alu_op        = outs.alu_op;
   assign pc_source     = outs.pc_source;
   assign state         = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : directed self-checking bench for multicycle_control
// Revision: 1.0
// ============================================================================
module tb_multicycle_control;

   localparam int WAIT_MAX = 15;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // {state, pcw,pcwc,irw,rw,iord,mr,mw,m2r,rdst,asa,ez, asb,aop,pcs}
   localparam logic [20:0] V_FETCH_GO   = {4'd0,  11'b10100100000, 6'b010000};
   localparam logic [20:0] V_FETCH_WAIT = {4'd0,  11'b00000100000, 6'b010000};
   localparam logic [20:0] V_DECODE     = {4'd1,  11'b00000000000, 6'b110000};
   localparam logic [20:0] V_MEM_ADDR   = {4'd2,  11'b00000000010, 6'b100000};
   localparam logic [20:0] V_MEM_RD     = {4'd3,  11'b00001100000, 6'b000000};
   localparam logic [20:0] V_MEM_WB     = {4'd4,  11'b00010001000, 6'b000000};
   localparam logic [20:0] V_MEM_WR     = {4'd5,  11'b00001010000, 6'b000000};
   localparam logic [20:0] V_R_EXEC     = {4'd6,  11'b00000000010, 6'b001000};
   localparam logic [20:0] V_R_WB       = {4'd7,  11'b00010000100, 6'b000000};
   localparam logic [20:0] V_BEQ        = {4'd8,  11'b01000000010, 6'b000101};
   localparam logic [20:0] V_JUMP       = {4'd9,  11'b10000000000, 6'b000010};
   localparam logic [20:0] V_I_ADDI     = {4'd10, 11'b00000000010, 6'b100000};
   localparam logic [20:0] V_I_ORI      = {4'd10, 11'b00000000011, 6'b101100};
   localparam logic [20:0] V_I_WB       = {4'd11, 11'b00010000000, 6'b000000};
   localparam logic [20:0] V_TRAP       = {4'd12, 11'b00000000000, 6'b000000};
   localparam logic [20:0] V_JAL        = {4'd13, 11'b10010001100, 6'b000010};

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, reg_write, i_or_d;
   logic       mem_read, mem_write, mem_to_reg, reg_dst, alu_src_a, ext_zero;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op, mem_fault;
   logic [3:0] state;
   logic [20:0] ctl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ctl = {state, pc_write, pc_write_cond, ir_write, reg_write, i_or_d, mem_read,
                 mem_write, mem_to_reg, reg_dst, alu_src_a, ext_zero,
                 alu_src_b, alu_op, pc_source};

   multicycle_control #(.WAIT_MAX(WAIT_MAX), .WAIT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .ir_write     (ir_write),
      .reg_write    (reg_write),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_to_reg   (mem_to_reg),
      .reg_dst      (reg_dst),
      .alu_src_a    (alu_src_a),
      .ext_zero     (ext_zero),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .pc_source    (pc_source),
      .illegal_op   (illegal_op),
      .mem_fault    (mem_fault),
      .state        (state)
   );

   task automatic test_reset();
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (ctl !== V_FETCH_WAIT || illegal_op !== 1'b0 || mem_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: ctl=%h ill=%b flt=%b expected ctl=%h ill=0 flt=0",
                  ctl, illegal_op, mem_fault, V_FETCH_WAIT);
      end
   endtask

   task automatic test_lw();
      logic [20:0] ev [5];
      ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_WB};
      mem_ready = 1'b1;
      opcode    = OP_LW;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (ctl !== ev[i]) begin
            n_fail++;
            $display("FAIL lw step %0d: got %h expected %h", i, ctl, ev[i]);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (state !== 4'd0) begin
         n_fail++;
         $display("FAIL lw_return: state=%0d expected 0", state);
      end
   endtask

   task automatic test_rtype_beq_ori();
      logic [27:0] tbl [11];
      tbl = '{{1'b1, OP_R,   V_FETCH_GO}, {1'b1, OP_R,   V_DECODE},
              {1'b1, OP_R,   V_R_EXEC},   {1'b1, OP_R,   V_R_WB},
              {1'b1, OP_BEQ, V_FETCH_GO}, {1'b1, OP_BEQ, V_DECODE},
              {1'b1, OP_BEQ, V_BEQ},
              {1'b1, OP_ORI, V_FETCH_GO}, {1'b1, OP_ORI, V_DECODE},
              {1'b1, OP_ORI, V_I_ORI},    {1'b1, OP_ORI, V_I_WB}};
      for (int i = 0; i < 11; i++) begin
         mem_ready = tbl[i][27];
         opcode    = tbl[i][26:21];
         #1;
         n_checks++;
         if (ctl !== tbl[i][20:0]) begin
            n_fail++;
            $display("FAIL rtype_beq_ori step %0d: got %h expected %h", i, ctl, tbl[i][20:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_jump_addi();
      logic [27:0] tbl [11];
      tbl = '{{1'b1, OP_SW,   V_FETCH_GO}, {1'b1, OP_SW,   V_DECODE},
              {1'b1, OP_SW,   V_MEM_ADDR}, {1'b1, OP_SW,   V_MEM_WR},
              {1'b1, OP_J,    V_FETCH_GO}, {1'b1, OP_J,    V_DECODE},
              {1'b1, OP_J,    V_JUMP},
              {1'b1, OP_ADDI, V_FETCH_GO}, {1'b1, OP_ADDI, V_DECODE},
              {1'b1, OP_ADDI, V_I_ADDI},   {1'b1, OP_ADDI, V_I_WB}};
      for (int i = 0; i < 11; i++) begin
         mem_ready = tbl[i][27];
         opcode    = tbl[i][26:21];
         #1;
         n_checks++;
         if (ctl !== tbl[i][20:0]) begin
            n_fail++;
            $display("FAIL sw_j_addi step %0d: got %h expected %h", i, ctl, tbl[i][20:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fetch_wait();
      logic [27:0] tbl [6];
      int irw_count = 0;
      tbl = '{{1'b0, OP_J, V_FETCH_WAIT}, {1'b0, OP_J, V_FETCH_WAIT},
              {1'b0, OP_J, V_FETCH_WAIT}, {1'b1, OP_J, V_FETCH_GO},
              {1'b1, OP_J, V_DECODE},     {1'b1, OP_J, V_JUMP}};
      for (int i = 0; i < 6; i++) begin
         mem_ready = tbl[i][27];
         opcode    = tbl[i][26:21];
         #1;
         if (ir_write === 1'b1) irw_count++;
         n_checks++;
         if (ctl !== tbl[i][20:0]) begin
            n_fail++;
            $display("FAIL fetch_wait step %0d: got %h expected %h", i, ctl, tbl[i][20:0]);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (irw_count != 1) begin
         n_fail++;
         $display("FAIL fetch_wait_irw_count: got %0d expected 1", irw_count);
      end
   endtask

   task automatic test_timeout();
      int rw_count  = 0;
      int flt_count = 0;
      logic [20:0] ev [3];
      ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR};
      mem_ready = 1'b1;
      opcode    = OP_LW;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (ctl !== ev[i]) begin
            n_fail++;
            $display("FAIL timeout_lead step %0d: got %h expected %h", i, ctl, ev[i]);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         #1;
         if (reg_write === 1'b1) rw_count++;
         if (mem_fault === 1'b1) flt_count++;
         n_checks++;
         if (ctl !== V_MEM_RD) begin
            n_fail++;
            $display("FAIL timeout_wait cycle %0d: got %h expected %h", i, ctl, V_MEM_RD);
         end
         @(posedge clk); #1;
      end
      #1;
      if (reg_write === 1'b1) rw_count++;
      n_checks++;
      if (ctl !== V_FETCH_WAIT || mem_fault !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_fault: ctl=%h flt=%b expected ctl=%h flt=1",
                  ctl, mem_fault, V_FETCH_WAIT);
      end
      @(posedge clk); #1;
      if (reg_write === 1'b1) rw_count++;
      n_checks++;
      if (mem_fault !== 1'b0 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL timeout_pulse_end: flt=%b state=%0d expected flt=0 state=0",
                  mem_fault, state);
      end
      n_checks++;
      if (rw_count != 0 || flt_count != 0) begin
         n_fail++;
         $display("FAIL timeout_side_effects: reg_write=%0d early_fault=%0d expected 0 0",
                  rw_count, flt_count);
      end
   endtask

   task automatic test_wait_boundary();
      logic [20:0] ev [3];
      ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR};
      mem_ready = 1'b1;
      opcode    = OP_SW;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (ctl !== ev[i]) begin
            n_fail++;
            $display("FAIL boundary_lead step %0d: got %h expected %h", i, ctl, ev[i]);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < WAIT_MAX; i++) begin
         mem_ready = (i == WAIT_MAX - 1);
         #1;
         n_checks++;
         if (ctl !== V_MEM_WR || mem_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_wait cycle %0d: ctl=%h flt=%b expected ctl=%h flt=0",
                     i, ctl, mem_fault, V_MEM_WR);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (ctl !== V_FETCH_WAIT || mem_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL boundary_done: ctl=%h flt=%b expected ctl=%h flt=0",
                  ctl, mem_fault, V_FETCH_WAIT);
      end
   endtask

   task automatic test_reset_mem_wr();
      logic [20:0] ev [3];
      ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR};
      mem_ready = 1'b1;
      opcode    = OP_SW;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (ctl !== ev[i]) begin
            n_fail++;
            $display("FAIL reset_wr_lead step %0d: got %h expected %h", i, ctl, ev[i]);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (mem_write !== 1'b1 || state !== 4'd5) begin
         n_fail++;
         $display("FAIL reset_wr_pre: mem_write=%b state=%0d expected 1 5", mem_write, state);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (mem_write !== 1'b0 || state !== 4'd0 || mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_wr_post: mem_write=%b state=%0d mem_read=%b expected 0 0 1",
                  mem_write, state, mem_read);
      end
   endtask

   task automatic test_trap();
      mem_ready = 1'b1;
      opcode    = OP_BAD;
      #1;
      n_checks++;
      if (ctl !== V_FETCH_GO) begin
         n_fail++;
         $display("FAIL trap_fetch: got %h expected %h", ctl, V_FETCH_GO);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== V_DECODE || illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_decode: ctl=%h ill=%b expected ctl=%h ill=0", ctl, illegal_op, V_DECODE);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (ctl !== V_TRAP || illegal_op !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_hold cycle %0d: ctl=%h ill=%b expected ctl=%h ill=1",
                     i, ctl, illegal_op, V_TRAP);
         end
         @(posedge clk); #1;
      end
      reset     = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (ctl !== V_FETCH_WAIT || illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_reset: ctl=%h ill=%b expected ctl=%h ill=0",
                  ctl, illegal_op, V_FETCH_WAIT);
      end
      mem_ready = 1'b1;
      opcode    = OP_JAL;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
`ifdef CTRL_JAL_EN
      if (ctl !== V_JAL || illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL jal_exec: ctl=%h ill=%b expected ctl=%h ill=0", ctl, illegal_op, V_JAL);
      end
`else
      if (ctl !== V_TRAP || illegal_op !== 1'b1) begin
         n_fail++;
         $display("FAIL jal_disabled: ctl=%h ill=%b expected ctl=%h ill=1", ctl, illegal_op, V_TRAP);
      end
`endif
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      opcode    = 6'b000000;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_lw();
      test_rtype_beq_ori();
      test_store_jump_addi();
      test_fetch_wait();
      test_timeout();
      test_wait_boundary();
      test_reset_mem_wr();
      test_trap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
